// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin merge of NUM_REQ valid/ready write streams into
// one FIFO write port. It throttles against the FIFO full flags and sequences
// FLUSH -> RECOVER -> RUN after reset and whenever FLUSH_REQ is seen in RUN.
// Optional feature macro: FIFO_ARB_WRCOUNT_EN builds a saturating count of
// accepted words since the last flush. Without it, WR_COUNT is tied to zero.
module fifo_wr_arbiter #(
    parameter int DATA_WIDTH   = 36,
    parameter int NUM_REQ      = 4,
    parameter int FLUSH_CYCLES = 4
) (
    input  logic                          WRCLK,
    input  logic                          RESET,
    input  logic [NUM_REQ-1:0]            REQ_VALID,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA,
    output logic [NUM_REQ-1:0]            REQ_READY,
    input  logic                          FLUSH_REQ,
    output logic                          FLUSH_BUSY,
    input  logic                          FIFO_FULL,
    input  logic                          FIFO_ALMOST_FULL,
    input  logic                          FIFO_OVERFLOW,
    output logic                          FIFO_WREN,
    output logic [DATA_WIDTH-1:0]         FIFO_WR_DATA,
    output logic                          FIFO_FLUSH,
    output logic [2:0]                    GRANT_ID,
    output logic                          OVERFLOW_ERR,
    output logic [15:0]                   WR_COUNT
);

    typedef enum logic [1:0] {
        ST_FLUSH,
        ST_RECOVER,
        ST_RUN
    } state_t;

    state_t                  state_q;
    logic [3:0]              phaseCnt_q;
    logic                    fifoFlush_q;
    logic                    flushBusy_q;
    logic                    overflowErr_q;
    logic                    wren_q;
    logic [DATA_WIDTH-1:0]   wrData_q;
    logic [2:0]              grantId_q;
    logic [2:0]              ptr_q;
    logic [2:0]              ptr_d;

    logic [7:0]              validPad;
    logic [2:0]              scanIdx;
    logic [2:0]              grantIdx;
    logic                    grantHit;
    logic                    canWrite;
    logic                    xfer;
    logic                    flushEntry;
    logic [DATA_WIDTH-1:0]   selData;

    // Wraps a requester index that has stepped past the top requester.
    function automatic logic [2:0] wrapIdx(input int v);
        if (v >= NUM_REQ) begin
            return 3'(v - NUM_REQ);
        end
        return 3'(v);
    endfunction

    assign validPad   = 8'(REQ_VALID);
    assign canWrite   = !FIFO_FULL && (!FIFO_ALMOST_FULL || !wren_q);
    assign flushEntry = (state_q == ST_RUN) && FLUSH_REQ;
    assign xfer       = (state_q == ST_RUN) && !FLUSH_REQ && canWrite && grantHit;
    assign ptr_d      = wrapIdx(int'(grantIdx) + 1);

    // Round-robin scan starting at the pointer; the first valid requester wins.
    always_comb begin
        grantHit = 1'b0;
        grantIdx = 3'd0;
        scanIdx  = 3'd0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scanIdx = wrapIdx(int'(ptr_q) + k);
            if (!grantHit && validPad[scanIdx]) begin
                grantHit = 1'b1;
                grantIdx = scanIdx;
            end
        end
    end

    // Ready goes only to the winner, and only when the word can be written.
    always_comb begin
        REQ_READY = '0;
        selData   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grantIdx == 3'(i)) begin
                REQ_READY[i] = xfer;
                selData      = REQ_DATA[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Flush sequencer: hold FLUSH, let the flags settle in RECOVER, then run.
    always_ff @(posedge WRCLK or posedge RESET) begin
        if (RESET) begin
            state_q       <= ST_FLUSH;
            phaseCnt_q    <= 4'd0;
            fifoFlush_q   <= 1'b1;
            flushBusy_q   <= 1'b1;
            overflowErr_q <= 1'b0;
        end else begin
            case (state_q)
                ST_FLUSH: begin
                    if (phaseCnt_q == 4'(FLUSH_CYCLES - 1)) begin
                        state_q     <= ST_RECOVER;
                        phaseCnt_q  <= 4'd0;
                        fifoFlush_q <= 1'b0;
                    end else begin
                        phaseCnt_q <= phaseCnt_q + 4'd1;
                    end
                end
                ST_RECOVER: begin
                    if (phaseCnt_q == 4'd1) begin
                        state_q     <= ST_RUN;
                        phaseCnt_q  <= 4'd0;
                        flushBusy_q <= 1'b0;
                    end else begin
                        phaseCnt_q <= phaseCnt_q + 4'd1;
                    end
                end
                ST_RUN: begin
                    if (FLUSH_REQ) begin
                        state_q       <= ST_FLUSH;
                        phaseCnt_q    <= 4'd0;
                        fifoFlush_q   <= 1'b1;
                        flushBusy_q   <= 1'b1;
                        overflowErr_q <= 1'b0;
                    end else if (FIFO_OVERFLOW) begin
                        overflowErr_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_FLUSH;
                    phaseCnt_q  <= 4'd0;
                    fifoFlush_q <= 1'b1;
                    flushBusy_q <= 1'b1;
                end
            endcase
        end
    end

    // Register the accepted word toward the FIFO and advance the pointer past it.
    always_ff @(posedge WRCLK or posedge RESET) begin
        if (RESET) begin
            wren_q    <= 1'b0;
            wrData_q  <= '0;
            grantId_q <= 3'd0;
            ptr_q     <= 3'd0;
        end else begin
            wren_q <= xfer;
            if (xfer) begin
                wrData_q  <= selData;
                grantId_q <= grantIdx;
                ptr_q     <= ptr_d;
            end
        end
    end

`ifdef FIFO_ARB_WRCOUNT_EN
    logic [15:0] wrCount_q;

    // Saturating count of accepted words since the last flush.
    always_ff @(posedge WRCLK or posedge RESET) begin
        if (RESET) begin
            wrCount_q <= 16'h0000;
        end else if (flushEntry) begin
            wrCount_q <= 16'h0000;
        end else if (xfer && (wrCount_q != 16'hFFFF)) begin
            wrCount_q <= wrCount_q + 16'h0001;
        end
    end

    assign WR_COUNT = wrCount_q;
`else
    assign WR_COUNT = 16'h0000;
`endif

    assign FIFO_WREN    = wren_q;
    assign FIFO_WR_DATA = wrData_q;
    assign FIFO_FLUSH   = fifoFlush_q;
    assign FLUSH_BUSY   = flushBusy_q;
    assign GRANT_ID     = grantId_q;
    assign OVERFLOW_ERR = overflowErr_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Testbench for fifo_wr_arbiter. It runs vector tables and hand-written
// sequences, then randomized traffic checked against a cycle-level behavioural
// model. The expected WR_COUNT follows FIFO_ARB_WRCOUNT_EN.
module tb_fifo_wr_arbiter;

    localparam int NR = 4;
    localparam int DW = 36;
    localparam int FC = 4;
`ifdef FIFO_ARB_WRCOUNT_EN
    localparam bit CountEn = 1'b1;
`else
    localparam bit CountEn = 1'b0;
`endif

    logic              WRCLK = 1'b0;
    logic              RESET = 1'b0;
    logic [NR-1:0]     REQ_VALID = '0;
    logic [NR*DW-1:0]  REQ_DATA = '0;
    logic [NR-1:0]     REQ_READY;
    logic              FLUSH_REQ = 1'b0;
    logic              FLUSH_BUSY;
    logic              FIFO_FULL = 1'b0;
    logic              FIFO_ALMOST_FULL = 1'b0;
    logic              FIFO_OVERFLOW = 1'b0;
    logic              FIFO_WREN;
    logic [DW-1:0]     FIFO_WR_DATA;
    logic              FIFO_FLUSH;
    logic [2:0]        GRANT_ID;
    logic              OVERFLOW_ERR;
    logic [15:0]       WR_COUNT;

    int checks = 0;
    int errors = 0;
    bit modelOn = 1'b1;

    // The model's view: cycles since the last flush entry, plus the write registers.
    int          mAge;
    int          mPtr;
    bit          mWren;
    logic [DW-1:0] mData;
    logic [2:0]  mGrant;
    bit          mOvf;
    int          mCount;

    typedef struct {
        logic [3:0]    valid;
        logic [3:0]    expReady;
        logic [DW-1:0] expData;
        logic [2:0]    expGrant;
    } vec_t;

    vec_t vecs[10];

    fifo_wr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .FLUSH_CYCLES(FC)) dut (
        .WRCLK(WRCLK),
        .RESET(RESET),
        .REQ_VALID(REQ_VALID),
        .REQ_DATA(REQ_DATA),
        .REQ_READY(REQ_READY),
        .FLUSH_REQ(FLUSH_REQ),
        .FLUSH_BUSY(FLUSH_BUSY),
        .FIFO_FULL(FIFO_FULL),
        .FIFO_ALMOST_FULL(FIFO_ALMOST_FULL),
        .FIFO_OVERFLOW(FIFO_OVERFLOW),
        .FIFO_WREN(FIFO_WREN),
        .FIFO_WR_DATA(FIFO_WR_DATA),
        .FIFO_FLUSH(FIFO_FLUSH),
        .GRANT_ID(GRANT_ID),
        .OVERFLOW_ERR(OVERFLOW_ERR),
        .WR_COUNT(WR_COUNT)
    );

    // Free-running write clock, period 10.
    always #5 WRCLK = ~WRCLK;

    // Hard stop in case the run never reaches its summary.
    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: got still running, expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] valid, input logic flushReq,
                                 input logic full, input logic almostFull, input logic overflow);
        REQ_VALID        = valid;
        FLUSH_REQ        = flushReq;
        FIFO_FULL        = full;
        FIFO_ALMOST_FULL = almostFull;
        FIFO_OVERFLOW    = overflow;
    endtask

    task automatic setFixedData();
        for (int i = 0; i < NR; i++) begin
            REQ_DATA[i*DW +: DW] = DW'(36'hA0 + i);
        end
    endtask

    function automatic bit modelRun();
        return mAge >= FC + 2;
    endfunction

    function automatic int modelWinner();
        for (int k = 0; k < NR; k++) begin
            int idx = (mPtr + k) % NR;
            if (((REQ_VALID >> idx) & 4'b0001) != 4'b0000) return idx;
        end
        return -1;
    endfunction

    function automatic logic [3:0] modelReady();
        int w = modelWinner();
        bit room = !FIFO_FULL && !(FIFO_ALMOST_FULL && mWren);
        if (modelRun() && !FLUSH_REQ && room && w >= 0) return 4'(1 << w);
        return 4'b0000;
    endfunction

    task automatic modelReset();
        mAge   = 0;
        mPtr   = 0;
        mWren  = 1'b0;
        mData  = '0;
        mGrant = 3'd0;
        mOvf   = 1'b0;
        mCount = 0;
    endtask

    task automatic modelUpdate();
        logic [3:0] r = modelReady();
        int w = modelWinner();
        bit run = modelRun();
        if (run && FLUSH_REQ) begin
            mAge   = 0;
            mOvf   = 1'b0;
            mCount = 0;
        end else begin
            if (mAge < FC + 2) mAge++;
            if (run && FIFO_OVERFLOW) mOvf = 1'b1;
        end
        mWren = (r != 4'b0000);
        if (r != 4'b0000) begin
            mData  = DW'(REQ_DATA >> (w * DW));
            mGrant = 3'(w);
            mPtr   = (w + 1) % NR;
            if (CountEn && mCount < 65535) mCount++;
        end
    endtask

    task automatic modelCompare();
        checkOutput("m_ready", 64'(REQ_READY), 64'(modelReady()));
        checkOutput("m_busy", 64'(FLUSH_BUSY), 64'(mAge < FC + 2));
        checkOutput("m_flush", 64'(FIFO_FLUSH), 64'(mAge < FC));
        checkOutput("m_wren", 64'(FIFO_WREN), 64'(mWren));
        checkOutput("m_data", 64'(FIFO_WR_DATA), 64'(mData));
        checkOutput("m_grant", 64'(GRANT_ID), 64'(mGrant));
        checkOutput("m_ovf", 64'(OVERFLOW_ERR), 64'(mOvf));
        checkOutput("m_count", 64'(WR_COUNT), 64'(mCount));
    endtask

    // Compare mid-cycle, then advance the model across the rising edge to the next negedge.
    task automatic stepClock();
        if (modelOn) modelCompare();
        @(posedge WRCLK);
        if (RESET) modelReset();
        else modelUpdate();
        @(negedge WRCLK);
    endtask

    initial begin
        vecs[0] = '{4'b1111, 4'b0001, 36'hA0, 3'd0};
        vecs[1] = '{4'b1111, 4'b0010, 36'hA1, 3'd1};
        vecs[2] = '{4'b1111, 4'b0100, 36'hA2, 3'd2};
        vecs[3] = '{4'b1111, 4'b1000, 36'hA3, 3'd3};
        vecs[4] = '{4'b1111, 4'b0001, 36'hA0, 3'd0};
        vecs[5] = '{4'b1001, 4'b1000, 36'hA3, 3'd3};
        vecs[6] = '{4'b0110, 4'b0010, 36'hA1, 3'd1};
        vecs[7] = '{4'b0001, 4'b0001, 36'hA0, 3'd0};
        vecs[8] = '{4'b0000, 4'b0000, 36'hA0, 3'd0};
        vecs[9] = '{4'b0101, 4'b0100, 36'hA2, 3'd2};

        setFixedData();
        modelReset();
        #1 RESET = 1'b1;
        #2;
        checkOutput("rst_flush", 64'(FIFO_FLUSH), 64'd1);
        checkOutput("rst_busy", 64'(FLUSH_BUSY), 64'd1);
        checkOutput("rst_wren", 64'(FIFO_WREN), 64'd0);
        checkOutput("rst_data", 64'(FIFO_WR_DATA), 64'd0);
        checkOutput("rst_ready", 64'(REQ_READY), 64'd0);
        checkOutput("rst_grant", 64'(GRANT_ID), 64'd0);
        checkOutput("rst_ovf", 64'(OVERFLOW_ERR), 64'd0);
        checkOutput("rst_count", 64'(WR_COUNT), 64'd0);
        @(negedge WRCLK);
        @(negedge WRCLK);
        RESET = 1'b0;

        // Startup: FLUSH for FC cycles, RECOVER for 2, RUN from cycle FC+3.
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
            #1;
            checkOutput("start_flush", 64'(FIFO_FLUSH), 64'(i <= FC));
            checkOutput("start_busy", 64'(FLUSH_BUSY), 64'(i <= FC + 2));
            checkOutput("start_wren", 64'(FIFO_WREN), 64'd0);
            stepClock();
        end

        // Round-robin order under various valid patterns.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].valid, 1'b0, 1'b0, 1'b0, 1'b0);
            #1;
            checkOutput($sformatf("rr_ready[%0d]", i), 64'(REQ_READY), 64'(vecs[i].expReady));
            stepClock();
            checkOutput($sformatf("rr_wren[%0d]", i), 64'(FIFO_WREN), 64'(vecs[i].expReady != 4'b0000));
            checkOutput($sformatf("rr_data[%0d]", i), 64'(FIFO_WR_DATA), 64'(vecs[i].expData));
            checkOutput($sformatf("rr_grant[%0d]", i), 64'(GRANT_ID), 64'(vecs[i].expGrant));
        end

        // Almost full: every other cycle; full: nothing.
        for (int k = 0; k < 6; k++) begin
            applyStimulus(4'b0100, 1'b0, 1'b0, 1'b1, 1'b0);
            #1;
            checkOutput("af_wren", 64'(FIFO_WREN), 64'(k % 2 == 0));
            checkOutput("af_ready", 64'(REQ_READY), (k % 2 == 1) ? 64'h4 : 64'h0);
            stepClock();
        end
        for (int k = 0; k < 2; k++) begin
            applyStimulus(4'b0100, 1'b0, 1'b1, 1'b1, 1'b0);
            #1;
            checkOutput("full_ready", 64'(REQ_READY), 64'd0);
            checkOutput("full_wren", 64'(FIFO_WREN), 64'(k == 0));
            stepClock();
        end

        // Overflow pulse in RUN becomes sticky.
        applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("ovf_before", 64'(OVERFLOW_ERR), 64'd0);
        applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);
        stepClock();
        for (int k = 0; k < 4; k++) begin
            applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
            #1;
            checkOutput("ovf_sticky", 64'(OVERFLOW_ERR), 64'd1);
            stepClock();
        end

        // Flush request beats a simultaneous valid; then the full flush timeline.
        checkOutput("count_pre_flush", 64'(WR_COUNT), CountEn ? 64'd12 : 64'd0);
        applyStimulus(4'b0010, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("fl_ready", 64'(REQ_READY), 64'd0);
        stepClock();
        checkOutput("fl_flush", 64'(FIFO_FLUSH), 64'd1);
        checkOutput("fl_ovf", 64'(OVERFLOW_ERR), 64'd0);
        checkOutput("fl_count", 64'(WR_COUNT), 64'd0);
        checkOutput("fl_wren", 64'(FIFO_WREN), 64'd0);
        for (int c = 1; c <= 7; c++) begin
            applyStimulus(4'b0010, 1'b0, 1'b0, 1'b0, c == 2);
            #1;
            checkOutput("flseq_flush", 64'(FIFO_FLUSH), 64'(c <= FC));
            checkOutput("flseq_ready", 64'(REQ_READY), (c == 7) ? 64'h2 : 64'h0);
            checkOutput("flseq_ovf", 64'(OVERFLOW_ERR), 64'd0);
            stepClock();
        end

        // Flush request held high keeps re-entering FLUSH; no transfer ever.
        for (int c = 0; c < 16; c++) begin
            applyStimulus(4'b1111, 1'b1, 1'b0, 1'b0, 1'b0);
            #1;
            checkOutput("hold_ready", 64'(REQ_READY), 64'd0);
            stepClock();
        end

        // Reset asserted while a write is pending.
        for (int c = 0; c < FC + 3; c++) begin
            applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
            stepClock();
        end
        applyStimulus(4'b1111, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        stepClock();
        checkOutput("mid_wren_before", 64'(FIFO_WREN), 64'd1);
        RESET = 1'b1;
        #1;
        modelReset();
        checkOutput("mid_wren", 64'(FIFO_WREN), 64'd0);
        checkOutput("mid_flush", 64'(FIFO_FLUSH), 64'd1);
        checkOutput("mid_busy", 64'(FLUSH_BUSY), 64'd1);
        checkOutput("mid_data", 64'(FIFO_WR_DATA), 64'd0);
        checkOutput("mid_grant", 64'(GRANT_ID), 64'd0);
        checkOutput("mid_ready", 64'(REQ_READY), 64'd0);
        stepClock();
        stepClock();
        RESET = 1'b0;

        // Randomized traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < NR; i++) begin
                REQ_DATA[i*DW +: DW] = {4'($urandom()), 32'($urandom())};
            end
            applyStimulus(4'($urandom()), $urandom_range(0, 29) == 0,
                          $urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0,
                          $urandom_range(0, 11) == 0);
            #1;
            stepClock();
        end
        setFixedData();

        // Long stream to exercise WR_COUNT saturation.
        RESET = 1'b1;
        #1;
        modelReset();
        @(negedge WRCLK);
        RESET = 1'b0;
        for (int c = 0; c < FC + 2; c++) begin
            applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
            stepClock();
        end
        modelOn = 1'b0;
        applyStimulus(4'b1111, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 65540; c++) begin
            stepClock();
        end
        modelOn = 1'b1;
        applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("sat_count", 64'(WR_COUNT), CountEn ? 64'hFFFF : 64'h0);
        stepClock();
        checkOutput("sat_hold", 64'(WR_COUNT), CountEn ? 64'hFFFF : 64'h0);
        applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        stepClock();
        checkOutput("sat_cleared", 64'(WR_COUNT), 64'd0);
        applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        stepClock();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
